// File: rtl/inst_fetch_buffer.sv
// Instruction-fetch buffer between the PC register and IF/ID.
// Issues fetch requests on an SRAM-like instruction interface, keeps the
// in-order responses in a small queue and hands {pc, inst} pairs to decode.
// A flush throws away everything buffered; responses that were still in
// flight at the flush are counted down and dropped in the DRAIN state.
//
// Handshakes (all sampled on the rising edge of clk):
//   fetch request : a request is accepted in any cycle where
//                   inst_req_o && inst_addr_ok_i; pc_ready_o reports exactly
//                   that, and upstream holds pc_i stable until it sees it.
//   response      : inst_data_ok_i marks one read word per cycle, returned in
//                   request order.
//   decode output : the head entry transfers in any cycle where
//                   id_valid_o && id_ready_i; id_valid_o never depends on
//                   id_ready_i, and a transfer frees the entry.
module inst_fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AW-1:0]            pc_i,
   input  logic                     pc_ce_i,
   output logic                     pc_ready_o,
   output logic                     inst_req_o,
   output logic [AW-1:0]            inst_addr_o,
   input  logic                     inst_addr_ok_i,
   input  logic [DW-1:0]            inst_rdata_i,
   input  logic                     inst_data_ok_i,
   input  logic                     flush_i,
   output logic                     id_valid_o,
   output logic [AW-1:0]            id_pc_o,
   output logic [DW-1:0]            id_inst_o,
   input  logic                     id_ready_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     dbg_state_o,
   output logic [$clog2(DEPTH):0]   dbg_discard_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t          state_q, state_n;
   logic [CW-1:0]   discard_q, discard_n;

   // Entry storage; pc/inst carry no reset, validity lives in filled_q.
   logic [AW-1:0]   pc_q   [DEPTH];
   logic [DW-1:0]   inst_q [DEPTH];
   logic [DEPTH-1:0] filled_q;

   // Pointers carry one extra wrap bit so tail-fill and tail-head give exact
   // occupancy even when every entry is allocated.
   logic [CW-1:0]   head_q, fill_q, tail_q;
   logic [PW-1:0]   head_idx, fill_idx, tail_idx;

   logic [CW-1:0]   pending;
   logic            full;
   logic            resp_fill;
   logic            resp_drop;
   logic            pop;
   logic            proto_err;

   assign head_idx = head_q[PW-1:0];
   assign fill_idx = fill_q[PW-1:0];
   assign tail_idx = tail_q[PW-1:0];

   assign count_o  = tail_q - head_q;
   assign pending  = tail_q - fill_q;
   assign full     = (count_o == CW'(DEPTH));

   assign inst_addr_o       = pc_i;
   assign id_pc_o           = pc_q[head_idx];
   assign id_inst_o         = inst_q[head_idx];
   assign dbg_state_o       = state_q;
   assign dbg_discard_cnt_o = discard_q;

   // Request, response classification and decode-side handshake.
   always_comb begin
      inst_req_o = !rst && pc_ce_i && !flush_i && (state_q == ST_RUN) && !full;
      pc_ready_o = inst_req_o && inst_addr_ok_i;
      resp_fill  = inst_data_ok_i && (state_q == ST_RUN) && (pending != '0);
      resp_drop  = inst_data_ok_i && (state_q == ST_DRAIN) && (discard_q != '0);
      proto_err  = inst_data_ok_i && !resp_fill && !resp_drop;
      id_valid_o = filled_q[head_idx] && !flush_i;
      pop        = id_valid_o && id_ready_i;
   end

   // Next state: a flush in RUN turns the in-flight requests into a discard
   // count; DRAIN counts dropped responses down and returns to RUN at zero.
   always_comb begin
      state_n   = state_q;
      discard_n = discard_q;
      if (flush_i) begin
         if (state_q == ST_RUN) begin
            discard_n = pending - CW'(resp_fill);
         end else begin
            discard_n = discard_q - CW'(resp_drop);
         end
         state_n = (discard_n != '0) ? ST_DRAIN : ST_RUN;
      end else if (resp_drop) begin
         discard_n = discard_q - CW'(1);
         state_n   = (discard_n != '0) ? ST_DRAIN : ST_RUN;
      end
   end

   // State register and discard counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         discard_q <= '0;
      end else begin
         state_q   <= state_n;
         discard_q <= discard_n;
      end
   end

   // Pointers and filled bits; a flush empties the queue and wins over any
   // same-cycle accept, fill or pop.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         head_q   <= '0;
         fill_q   <= '0;
         tail_q   <= '0;
         filled_q <= '0;
      end else begin
         if (pc_ready_o) begin
            tail_q <= tail_q + CW'(1);
         end
         if (resp_fill) begin
            filled_q[fill_idx] <= 1'b1;
            fill_q             <= fill_q + CW'(1);
         end
         if (pop) begin
            filled_q[head_idx] <= 1'b0;
            head_q             <= head_q + CW'(1);
         end
      end
   end

   // Payload writes: pc at allocation, instruction word when it returns.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) begin
         if (pc_ready_o) begin
            pc_q[tail_idx] <= pc_i;
         end
         if (resp_fill) begin
            inst_q[fill_idx] <= inst_rdata_i;
         end
      end
   end

   // A response with nothing pending and nothing left to discard means the
   // memory side broke the in-order, one-per-request contract.
   a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst) !proto_err);
   a_count_bound    : assert property (@(posedge clk) disable iff (rst) count_o <= CW'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: a one-cycle in-order memory model, an
// upstream PC that advances on pc_ready_o, and a scoreboard of fetched pcs.
module tb_inst_fetch_buffer;

   localparam int AW = 32;
   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [AW-1:0] pc_i;
   logic          pc_ce_i;
   logic          pc_ready_o;
   logic          inst_req_o;
   logic [AW-1:0] inst_addr_o;
   logic          inst_addr_ok_i;
   logic [DW-1:0] inst_rdata_i;
   logic          inst_data_ok_i;
   logic          flush_i;
   logic          id_valid_o;
   logic [AW-1:0] id_pc_o;
   logic [DW-1:0] id_inst_o;
   logic          id_ready_i;
   logic [2:0]    count_o;
   logic          dbg_state_o;
   logic [2:0]    dbg_discard_cnt_o;

   inst_fetch_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
      .clk               (clk),
      .rst               (rst),
      .pc_i              (pc_i),
      .pc_ce_i           (pc_ce_i),
      .pc_ready_o        (pc_ready_o),
      .inst_req_o        (inst_req_o),
      .inst_addr_o       (inst_addr_o),
      .inst_addr_ok_i    (inst_addr_ok_i),
      .inst_rdata_i      (inst_rdata_i),
      .inst_data_ok_i    (inst_data_ok_i),
      .flush_i           (flush_i),
      .id_valid_o        (id_valid_o),
      .id_pc_o           (id_pc_o),
      .id_inst_o         (id_inst_o),
      .id_ready_i        (id_ready_i),
      .count_o           (count_o),
      .dbg_state_o       (dbg_state_o),
      .dbg_discard_cnt_o (dbg_discard_cnt_o)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [AW-1:0] exp_q[$];   // pcs allocated in the buffer, oldest first
   logic [AW-1:0] mem_q[$];   // pcs accepted by memory, not yet answered

   // per-cycle knobs applied by cycle()
   logic k_rst, k_ce, k_aok, k_flush, k_rdy, k_hold;
   logic pc_load_en;
   logic [AW-1:0] pc_load_val;
   logic adv;

   typedef struct {
      logic       ce;
      logic       aok;
      logic       flush;
      logic       exp_req;
      logic       exp_ready;
      logic       exp_valid;
      logic [2:0] exp_count;
   } vec_t;
   vec_t tbl[11];

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[7:0], a[31:8]} ^ 32'hA5C3_5A3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver + memory model + monitor ----------------
   // Drives one cycle at the falling edge, then samples 3 ns later, still
   // ahead of the next rising edge.
   task automatic cycle();
      logic [AW-1:0] a;
      @(negedge clk);
      rst            = k_rst;
      pc_ce_i        = k_ce;
      inst_addr_ok_i = k_aok;
      flush_i        = k_flush;
      id_ready_i     = k_rdy;
      if (pc_load_en) begin
         pc_i       = pc_load_val;
         pc_load_en = 1'b0;
      end else if (adv) begin
         pc_i = pc_i + 32'd4;
      end
      if (!k_rst && !k_hold && mem_q.size() > 0) begin
         a              = mem_q.pop_front();
         inst_data_ok_i = 1'b1;
         inst_rdata_i   = mem_word(a);
      end else begin
         inst_data_ok_i = 1'b0;
         inst_rdata_i   = $urandom;
      end
      #3;
      chk("count_model", 32'(count_o), 32'(exp_q.size()));
      if (k_rst) begin
         mem_q.delete();
         exp_q.delete();
         adv = 1'b0;
      end else if (flush_i) begin
         exp_q.delete();
         adv = 1'b0;
      end else begin
         if (inst_req_o) chk("addr_eq_pc", inst_addr_o, pc_i);
         if (id_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_pop: got pc %0h expected no output", id_pc_o);
            end else begin
               a = exp_q.pop_front();
               chk("sb_pc", id_pc_o, a);
               chk("sb_inst", id_inst_o, mem_word(a));
            end
         end
         if (pc_ready_o) begin
            exp_q.push_back(pc_i);
            mem_q.push_back(pc_i);
         end
         adv = pc_ready_o;
      end
   endtask

   task automatic pc_load(input logic [AW-1:0] v);
      pc_load_en  = 1'b1;
      pc_load_val = v;
   endtask

   task automatic drain();
      logic done;
      done    = 1'b0;
      k_ce    = 1'b0;
      k_rdy   = 1'b1;
      k_hold  = 1'b0;
      k_flush = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (count_o == 3'd0 && mem_q.size() == 0 && dbg_state_o == 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_done", 32'(done), 32'd1);
   endtask

   task automatic wait_head(input string name, input logic [AW-1:0] epc);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (id_valid_o) begin
            found = 1'b1;
            chk({name, "_pc"}, id_pc_o, epc);
            chk({name, "_inst"}, id_inst_o, mem_word(epc));
            break;
         end
      end
      chk({name, "_seen"}, 32'(found), 32'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1; pc_i = '0; pc_ce_i = 1'b0; inst_addr_ok_i = 1'b0;
      inst_rdata_i = '0; inst_data_ok_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
      k_rst = 1'b1; k_ce = 1'b0; k_aok = 1'b1; k_flush = 1'b0; k_rdy = 1'b1; k_hold = 1'b0;
      pc_load_en = 1'b0; pc_load_val = '0; adv = 1'b0;

      //            ce    aok   flush req   ready valid count
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

      // reset: request gated even with ce high
      repeat (2) cycle();
      k_ce = 1'b1;
      cycle();
      chk("rst_req", 32'(inst_req_o), 32'd0);
      k_rst = 1'b0;
      k_ce  = 1'b0;
      cycle();
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_valid", 32'(id_valid_o), 32'd0);
      chk("rst_state", 32'(dbg_state_o), 32'd0);
      chk("rst_discard", 32'(dbg_discard_cnt_o), 32'd0);

      // table-driven single-cycle behaviour
      pc_load(32'h0000_1000);
      for (int i = 0; i < 11; i++) begin
         k_ce = tbl[i].ce; k_aok = tbl[i].aok; k_flush = tbl[i].flush;
         cycle();
         chk($sformatf("tbl%0d_req", i), 32'(inst_req_o), 32'(tbl[i].exp_req));
         chk($sformatf("tbl%0d_ready", i), 32'(pc_ready_o), 32'(tbl[i].exp_ready));
         chk($sformatf("tbl%0d_valid", i), 32'(id_valid_o), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(tbl[i].exp_count));
      end
      k_flush = 1'b0;
      drain();

      // streaming at one instruction per cycle
      pc_load(32'h0);
      k_ce = 1'b1; k_aok = 1'b1; k_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (i == 0) chk("st_first_accept", 32'(pc_ready_o), 32'd1);
         if (i == 1) chk("st_valid_early", 32'(id_valid_o), 32'd0);
         if (i == 2) chk("st_first_pc", id_pc_o, 32'h0);
         if (i >= 2) begin
            chk("st_valid", 32'(id_valid_o), 32'd1);
            chk("st_count", 32'(count_o), 32'd2);
         end
      end
      drain();

      // fill to DEPTH with decode stalled, then release
      pc_load(32'h0);
      k_ce = 1'b1; k_aok = 1'b1; k_rdy = 1'b0;
      repeat (6) cycle();
      chk("full_count", 32'(count_o), 32'd4);
      chk("full_req", 32'(inst_req_o), 32'd0);
      chk("full_ready", 32'(pc_ready_o), 32'd0);
      chk("full_pc_held", pc_i, 32'h10);
      k_rdy = 1'b1;
      cycle();
      chk("full_pop_no_req", 32'(inst_req_o), 32'd0);
      chk("full_pop_pc", id_pc_o, 32'h0);
      cycle();
      chk("full_resume_count", 32'(count_o), 32'd3);
      chk("full_resume_addr", inst_addr_o, 32'h10);
      chk("full_resume_ready", 32'(pc_ready_o), 32'd1);
      drain();

      // memory back-pressure on the request
      pc_load(32'h40);
      k_ce = 1'b1; k_aok = 1'b0; k_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_req", 32'(inst_req_o), 32'd1);
         chk("stall_addr", inst_addr_o, 32'h40);
         chk("stall_ready", 32'(pc_ready_o), 32'd0);
         chk("stall_count", 32'(count_o), 32'd0);
      end
      k_aok = 1'b1;
      cycle();
      chk("stall_accept", 32'(pc_ready_o), 32'd1);
      k_ce = 1'b0;
      cycle();
      chk("stall_count_after", 32'(count_o), 32'd1);
      drain();

      // flush with one filled and two in-flight entries
      pc_load(32'h80);
      k_ce = 1'b1; k_aok = 1'b1; k_rdy = 1'b0; k_hold = 1'b1;
      cycle();
      k_hold = 1'b0;
      cycle();
      k_hold = 1'b1;
      cycle();
      k_ce = 1'b0; k_flush = 1'b1;
      cycle();
      chk("fl_pre_count", 32'(count_o), 32'd3);
      chk("fl_req", 32'(inst_req_o), 32'd0);
      chk("fl_valid_masked", 32'(id_valid_o), 32'd0);
      k_flush = 1'b0; k_ce = 1'b1; k_hold = 1'b0;
      pc_load(32'h100);
      cycle();
      chk("fl_count", 32'(count_o), 32'd0);
      chk("fl_valid", 32'(id_valid_o), 32'd0);
      chk("fl_drain_req", 32'(inst_req_o), 32'd0);
      chk("fl_state", 32'(dbg_state_o), 32'd1);
      chk("fl_discard2", 32'(dbg_discard_cnt_o), 32'd2);
      cycle();
      chk("fl_drain_req2", 32'(inst_req_o), 32'd0);
      chk("fl_discard1", 32'(dbg_discard_cnt_o), 32'd1);
      cycle();
      chk("fl_run", 32'(dbg_state_o), 32'd0);
      chk("fl_discard0", 32'(dbg_discard_cnt_o), 32'd0);
      chk("fl_refetch_addr", inst_addr_o, 32'h100);
      chk("fl_refetch_ready", 32'(pc_ready_o), 32'd1);
      k_ce = 1'b0; k_rdy = 1'b1;
      wait_head("fl_head", 32'h100);
      drain();

      // accept, response and pop in one cycle at count 3
      pc_load(32'h200);
      k_ce = 1'b1; k_aok = 1'b1; k_rdy = 1'b0; k_hold = 1'b0;
      repeat (3) cycle();
      k_rdy = 1'b1;
      cycle();
      chk("sim_count_pre", 32'(count_o), 32'd3);
      chk("sim_accept", 32'(pc_ready_o), 32'd1);
      chk("sim_resp", 32'(inst_data_ok_i), 32'd1);
      chk("sim_pop_pc", id_pc_o, 32'h200);
      k_ce = 1'b0;
      cycle();
      chk("sim_count_post", 32'(count_o), 32'd3);
      drain();

      // flush in the same cycle as a response
      pc_load(32'h280);
      k_ce = 1'b1; k_aok = 1'b1; k_rdy = 1'b1; k_hold = 1'b1;
      repeat (2) cycle();
      k_ce = 1'b0; k_flush = 1'b1; k_hold = 1'b0;
      cycle();
      chk("fr_resp_in_flush", 32'(inst_data_ok_i), 32'd1);
      k_flush = 1'b0; k_hold = 1'b1;
      cycle();
      chk("fr_state", 32'(dbg_state_o), 32'd1);
      chk("fr_discard", 32'(dbg_discard_cnt_o), 32'd1);
      k_hold = 1'b0;
      cycle();
      chk("fr_discard_hold", 32'(dbg_discard_cnt_o), 32'd1);
      cycle();
      chk("fr_run", 32'(dbg_state_o), 32'd0);
      chk("fr_discard0", 32'(dbg_discard_cnt_o), 32'd0);
      drain();

      // reset with three entries queued
      pc_load(32'h2C0);
      k_ce = 1'b1; k_aok = 1'b1; k_rdy = 1'b0;
      repeat (3) cycle();
      k_ce = 1'b0;
      cycle();
      chk("rq_count", 32'(count_o), 32'd3);
      k_rst = 1'b1; k_ce = 1'b1;
      cycle();
      chk("rq_req_in_rst", 32'(inst_req_o), 32'd0);
      cycle();
      chk("rq_count0", 32'(count_o), 32'd0);
      chk("rq_valid0", 32'(id_valid_o), 32'd0);
      chk("rq_req0", 32'(inst_req_o), 32'd0);
      k_rst = 1'b0;
      pc_load(32'h300);
      cycle();
      chk("rq_restart_addr", inst_addr_o, 32'h300);
      chk("rq_restart_ready", 32'(pc_ready_o), 32'd1);
      k_ce = 1'b0; k_rdy = 1'b1;
      wait_head("rq_head", 32'h300);
      drain();

      // random traffic, scoreboard does the checking
      pc_load(32'h4000);
      for (int i = 0; i < 120; i++) begin
         k_ce    = ($urandom_range(0, 3) != 0);
         k_aok   = ($urandom_range(0, 3) != 0);
         k_rdy   = ($urandom_range(0, 3) != 0);
         k_hold  = ($urandom_range(0, 3) == 0);
         k_flush = ($urandom_range(0, 19) == 0);
         cycle();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
